// File: rtl/keypad_operand_entry_if.sv
// Keypad/multiplier-side bundle for keypad_operand_entry: key events and handshake in,
// signed operands and display state out.
interface keypad_operand_entry_if #(
   parameter int unsigned WIDTH = 8
);
   logic [3:0]       key_value;
   logic             key_pressed;
   logic             op_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             op_valid;
   logic [WIDTH-1:0] temp_value;
   logic             temp_neg;
   logic             active_operand;
   logic             entry_err;

   modport master (
      output key_value, key_pressed, op_ready,
      input  A, B, op_valid, temp_value, temp_neg, active_operand, entry_err
   );

   modport slave (
      input  key_value, key_pressed, op_ready,
      output A, B, op_valid, temp_value, temp_neg, active_operand, entry_err
   );
endinterface

// File: rtl/keypad_operand_entry.sv
// Collects decimal keypad digits into signed operands A/B and hands them to the Booth core.
// Define KEYPAD_BACKSPACE_EN to enable the backspace key (4'hE); otherwise it is an undefined key.
module keypad_operand_entry #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned MAX_DIGITS = 3
) (
   input logic                  clk,
   input logic                  rst,
   keypad_operand_entry_if.slave bus
);
   localparam int unsigned EW = WIDTH + 4;
   localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

   // Largest enterable magnitude, 2^(WIDTH-1)-1, at accumulator width.
   localparam logic [EW-1:0] MAX_MAG = {5'b0, {(WIDTH - 1){1'b1}}};

   localparam logic [3:0] KEY_NEXT  = 4'hA;
   localparam logic [3:0] KEY_SIGN  = 4'hB;
   localparam logic [3:0] KEY_CLEAR = 4'hC;
   localparam logic [3:0] KEY_ENTER = 4'hD;
`ifdef KEYPAD_BACKSPACE_EN
   localparam logic [3:0] KEY_BACK  = 4'hE;
`endif

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             key_q;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             act_q, act_d;

   logic             key_event;
   logic             is_digit;
   logic             digit_ok;
   logic [EW-1:0]    acc;
   logic [WIDTH-1:0] signed_val;

   assign key_event  = bus.key_pressed & ~key_q;
   assign is_digit   = (bus.key_value <= 4'd9);
   assign acc        = EW'(mag_q) * EW'(10) + EW'(bus.key_value);
   assign digit_ok   = (cnt_q != CW'(MAX_DIGITS)) && (acc <= MAX_MAG);
   // Negating zero yields zero, so "-0" commits as 0.
   assign signed_val = neg_q ? (WIDTH'(0) - mag_q) : mag_q;

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      a_d     = a_q;
      b_d     = b_q;
      valid_d = valid_q;
      err_d   = 1'b0;

      case (state_q)
         ENTER_A, ENTER_B: begin
            if (key_event) begin
               if (is_digit) begin
                  if (digit_ok) begin
                     mag_d = WIDTH'(acc);
                     cnt_d = cnt_q + CW'(1);
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  case (bus.key_value)
                     KEY_NEXT: begin
                        if (state_q == ENTER_A && cnt_q != '0) begin
                           a_d     = signed_val;
                           mag_d   = '0;
                           cnt_d   = '0;
                           neg_d   = 1'b0;
                           state_d = ENTER_B;
                        end else begin
                           err_d = 1'b1;
                        end
                     end
                     KEY_SIGN: neg_d = ~neg_q;
                     KEY_CLEAR: begin
                        mag_d   = '0;
                        cnt_d   = '0;
                        neg_d   = 1'b0;
                        a_d     = '0;
                        b_d     = '0;
                        state_d = ENTER_A;
                     end
                     KEY_ENTER: begin
                        // B magnitude and sign stay in place so the display keeps showing B in HOLD.
                        if (state_q == ENTER_B && cnt_q != '0) begin
                           b_d     = signed_val;
                           valid_d = 1'b1;
                           state_d = HOLD;
                        end else begin
                           err_d = 1'b1;
                        end
                     end
`ifdef KEYPAD_BACKSPACE_EN
                     KEY_BACK: begin
                        if (cnt_q != '0) begin
                           mag_d = mag_q / WIDTH'(10);
                           cnt_d = cnt_q - CW'(1);
                        end else begin
                           err_d = 1'b1;
                        end
                     end
`endif
                     default: err_d = 1'b1;
                  endcase
               end
            end
         end
         HOLD: begin
            // Keys are ignored here; only the core handshake releases the operands.
            if (valid_q && bus.op_ready) begin
               valid_d = 1'b0;
               mag_d   = '0;
               cnt_d   = '0;
               neg_d   = 1'b0;
               state_d = ENTER_A;
            end
         end
         default: state_d = ENTER_A;
      endcase

      act_d = (state_d != ENTER_A);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ENTER_A;
         key_q   <= 1'b0;
         mag_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= bus.key_pressed;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         a_q     <= a_d;
         b_q     <= b_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         act_q   <= act_d;
      end
   end

   assign bus.A              = a_q;
   assign bus.B              = b_q;
   assign bus.op_valid       = valid_q;
   assign bus.temp_value     = mag_q;
   assign bus.temp_neg       = neg_q;
   assign bus.active_operand = act_q;
   assign bus.entry_err      = err_q;
endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed + randomized bench for keypad_operand_entry against a per-cycle behavioural model.
module tb_keypad_operand_entry;
   localparam int unsigned WIDTH = 8;
   localparam int MAXD    = 3;
   localparam int MAX_MAG = (1 << (WIDTH - 1)) - 1;
   localparam int MASK    = (1 << WIDTH) - 1;
   localparam int K_NEXT  = 10;
   localparam int K_SIGN  = 11;
   localparam int K_CLEAR = 12;
   localparam int K_ENTER = 13;
   localparam int K_BACK  = 14;

   logic clk = 1'b0;
   logic rst;
   bit   rdy;

   keypad_operand_entry_if #(.WIDTH(WIDTH)) bus ();

   keypad_operand_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: stage 0 = entering A, 1 = entering B, 2 = holding operands.
   int m_stage, m_mag, m_cnt, m_a, m_b;
   bit m_neg, m_valid, m_err, m_kp;
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit kp, input int k, input bit r);
      bit ev;
      int nv;
      if (r) begin
         m_stage = 0; m_mag = 0; m_cnt = 0; m_a = 0; m_b = 0;
         m_neg = 0; m_valid = 0; m_err = 0; m_kp = 0;
         return;
      end
      ev    = kp && !m_kp;
      m_kp  = kp;
      m_err = 0;
      if (m_stage == 2) begin
         if (m_valid && rdy) begin
            m_valid = 0; m_mag = 0; m_cnt = 0; m_neg = 0; m_stage = 0;
         end
      end else if (ev) begin
         if (k <= 9) begin
            nv = m_mag * 10 + k;
            if (m_cnt == MAXD || nv > MAX_MAG) m_err = 1;
            else begin m_mag = nv; m_cnt++; end
         end else if (k == K_NEXT) begin
            if (m_stage == 0 && m_cnt > 0) begin
               m_a = m_neg ? -m_mag : m_mag;
               m_mag = 0; m_cnt = 0; m_neg = 0; m_stage = 1;
            end else m_err = 1;
         end else if (k == K_SIGN) begin
            m_neg = !m_neg;
         end else if (k == K_CLEAR) begin
            m_mag = 0; m_cnt = 0; m_neg = 0; m_a = 0; m_b = 0; m_stage = 0;
         end else if (k == K_ENTER) begin
            if (m_stage == 1 && m_cnt > 0) begin
               m_b = m_neg ? -m_mag : m_mag;
               m_valid = 1; m_stage = 2;
            end else m_err = 1;
`ifdef KEYPAD_BACKSPACE_EN
         end else if (k == K_BACK) begin
            if (m_cnt > 0) begin m_mag = m_mag / 10; m_cnt--; end
            else m_err = 1;
`endif
         end else begin
            m_err = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("A", 32'(bus.A), m_a & MASK);
      chk("B", 32'(bus.B), m_b & MASK);
      chk("op_valid", 32'(bus.op_valid), 32'(m_valid));
      chk("temp_value", 32'(bus.temp_value), m_mag);
      chk("temp_neg", 32'(bus.temp_neg), 32'(m_neg));
      chk("active_operand", 32'(bus.active_operand), (m_stage != 0) ? 1 : 0);
      chk("entry_err", 32'(bus.entry_err), 32'(m_err));
   endtask

   // One clock: drive at the falling edge, let the rising edge act, compare at the next falling edge.
   task automatic cycle(input bit kp, input int k, input bit r);
      bus.key_pressed = kp;
      bus.key_value   = 4'(k);
      bus.op_ready    = rdy;
      rst             = r;
      model_step(kp, k, r);
      @(negedge clk);
      check_all();
   endtask

   task automatic press(input int k);
      cycle(1'b1, k, 1'b0);
      cycle(1'b0, k, 1'b0);
   endtask

   initial begin
      rdy = 0;
      cycle(1'b0, 0, 1'b1);
      chk("rst_A", 32'(bus.A), 0);
      chk("rst_active", 32'(bus.active_operand), 0);

      // 12 x 3 with the core stalled for five cycles.
      press(1); press(2); press(K_NEXT); press(3); press(K_ENTER);
      repeat (5) begin
         cycle(1'b0, 0, 1'b0);
         chk("hold_valid", 32'(bus.op_valid), 1);
      end
      chk("A_12", 32'(bus.A), 12);
      chk("B_3", 32'(bus.B), 3);
      rdy = 1; cycle(1'b0, 0, 1'b0); rdy = 0;
      chk("valid_drop", 32'(bus.op_valid), 0);
      chk("active_back", 32'(bus.active_operand), 0);
      chk("A_kept", 32'(bus.A), 12);

      // Negative operands at the range limit.
      press(1); press(2); press(7); press(K_SIGN); press(K_NEXT);
      press(5); press(K_SIGN); press(K_ENTER);
      chk("A_m127", 32'(bus.A), 32'h81);
      chk("B_m5", 32'(bus.B), 32'hFB);
      chk("valid_neg", 32'(bus.op_valid), 1);
      rdy = 1; cycle(1'b0, 0, 1'b0); rdy = 0;

      // Range overflow and digit-count limit.
      press(1); press(2);
      cycle(1'b1, 8, 1'b0);
      chk("err_range", 32'(bus.entry_err), 1);
      cycle(1'b0, 8, 1'b0);
      chk("err_pulse_end", 32'(bus.entry_err), 0);
      chk("temp_12", 32'(bus.temp_value), 12);
      press(K_CLEAR); press(0); press(0); press(0);
      cycle(1'b1, 0, 1'b0);
      chk("err_count", 32'(bus.entry_err), 1);
      cycle(1'b0, 0, 1'b0);

      // Long hold yields one key event.
      press(K_CLEAR);
      repeat (10) cycle(1'b1, 7, 1'b0);
      cycle(1'b0, 7, 1'b0);
      chk("hold_one_digit", 32'(bus.temp_value), 7);

      // Enter with no B pending, clear wiping A, keys ignored in HOLD.
      press(K_CLEAR);
      cycle(1'b1, K_ENTER, 1'b0);
      chk("err_enter_a", 32'(bus.entry_err), 1);
      chk("enter_a_stays", 32'(bus.active_operand), 0);
      cycle(1'b0, K_ENTER, 1'b0);
      press(9); press(K_NEXT); press(4); press(5); press(K_CLEAR);
      chk("clear_temp", 32'(bus.temp_value), 0);
      chk("clear_A", 32'(bus.A), 0);
      chk("clear_active", 32'(bus.active_operand), 0);
      press(1); press(K_NEXT); press(2); press(K_ENTER);
      press(3); press(K_CLEAR); press(K_NEXT); press(15);
      chk("hold_A", 32'(bus.A), 1);
      chk("hold_temp", 32'(bus.temp_value), 2);
      chk("hold_valid2", 32'(bus.op_valid), 1);
      rdy = 1; cycle(1'b0, 0, 1'b0); rdy = 0;

      // Reset in the middle of entering B.
      press(1); press(2); press(K_NEXT); press(3);
      cycle(1'b0, 0, 1'b1);
      chk("midrst_A", 32'(bus.A), 0);
      chk("midrst_temp", 32'(bus.temp_value), 0);
      chk("midrst_active", 32'(bus.active_operand), 0);

      // Backspace key.
      press(1); press(2);
      cycle(1'b1, K_BACK, 1'b0);
`ifdef KEYPAD_BACKSPACE_EN
      chk("bs_temp", 32'(bus.temp_value), 1);
      chk("bs_err", 32'(bus.entry_err), 0);
`else
      chk("bs_temp", 32'(bus.temp_value), 12);
      chk("bs_err", 32'(bus.entry_err), 1);
`endif
      cycle(1'b0, K_BACK, 1'b0);
      press(K_CLEAR);

      // Randomized key traffic, handshakes and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         int k;
         bit kp, r;
         kp  = ($urandom_range(0, 2) != 0);
         k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
         rdy = ($urandom_range(0, 3) == 0);
         r   = ($urandom_range(0, 199) == 0);
         cycle(kp, k, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/keypad_operand_entry.md
Name: keypad_operand_entry

Overview:
- Parametrised successor to the keypad number-storage stage in the Booth multiplier datapath.
- Accumulates decimal keypad digits into two signed two's-complement operands A and B.
- Handles sign entry, clear, range and digit-count checking.
- Presents A/B to the multiplier core through an op_valid/op_ready handshake.
- Sits between the keypad decoder/debouncer and the Booth multiplier core; temp_value feeds the display driver.

Parameters:
- WIDTH, 8: operand width in bits (signed); legal range 4..16.
- MAX_DIGITS, 3: maximum decimal digits accepted per operand.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- key_value  input  4  decoded key code, valid while key_pressed is high.
- key_pressed  input  1  debounced, synchronised key-down level.
- op_ready  input  1  multiplier core can accept operands.
- A  output  WIDTH  signed operand A.
- B  output  WIDTH  signed operand B.
- op_valid  output  1  A/B are valid and stable.
- temp_value  output  WIDTH  magnitude of the operand being entered, for display.
- temp_neg  output  1  sign flag of the operand being entered.
- active_operand  output  1  0 = entering A, 1 = entering B.
- entry_err  output  1  one-cycle pulse on a rejected key.

Behaviour:
- Reset (synchronous, active-high, also mid-operation):
  - A, B, temp_value, temp_neg, op_valid, entry_err, active_operand = 0.
  - State = ENTER_A; internal key_pressed_q = 0, digit_count = 0.
- Key event: key_pressed & ~key_pressed_q. Exactly one event per press regardless of hold length. All effects are visible on the cycle after the event.
- Key codes:
  - 0-9: digit.
  - 4'hA: multiply/next operand.
  - 4'hB: sign toggle.
  - 4'hC: clear.
  - 4'hD: enter.
  - 4'hE: backspace (see optional feature).
  - 4'hF: undefined.
- MAX_MAG = 2^(WIDTH-1)-1. Range is symmetric; -2^(WIDTH-1) cannot be entered.
- Digit accumulation: new = mag*10 + d, computed in WIDTH+4 bits.
  - Rejected (mag unchanged, entry_err pulses) if digit_count == MAX_DIGITS or new > MAX_MAG.
  - Otherwise mag <= new and digit_count increments. Leading zeros count as digits.
- States:
  - ENTER_A (active_operand=0):
    - Digit: accumulate.
    - 4'hB: toggle temp_neg.
    - 4'hA with digit_count > 0: A <= temp_neg ? -mag : mag; clear mag, count and neg; go to ENTER_B.
    - 4'hA with digit_count = 0: entry_err.
    - 4'hD: entry_err.
  - ENTER_B (active_operand=1):
    - Digit and 4'hB: as in ENTER_A.
    - 4'hD with digit_count > 0: B <= signed value; op_valid <= 1; go to HOLD.
    - 4'hD with digit_count = 0: entry_err.
    - 4'hA: entry_err.
  - HOLD:
    - op_valid = 1; A and B stable.
    - All key events ignored, no entry_err (this includes clear).
    - When op_valid & op_ready: next cycle op_valid = 0, mag/count/neg cleared, state = ENTER_A. A and B retain their values.
    - A key event in the same cycle as the handshake is ignored.
- Clear (4'hC) in ENTER_A or ENTER_B: mag, count, neg, A and B = 0; state = ENTER_A.
- Sign: -0 is stored as 0. temp_neg may still display as set before commit.
- Undefined keys in entry states: entry_err, no other effect.
- temp_value = mag register; in HOLD it shows the magnitude of B.

Optional Feature:
- Macro: KEYPAD_BACKSPACE_EN.
- Defined: key 4'hE in ENTER_A/ENTER_B sets mag <= mag/10 and decrements digit_count.
  - With digit_count = 0: entry_err.
  - temp_neg unchanged.
- Undefined: 4'hE is treated as an undefined key (entry_err); no divider is synthesised.

Test Plan (WIDTH=8, MAX_DIGITS=3):
- Keys 1,2,A,3,D with op_ready=0 for 5 cycles, then 1 -> A=8'd12, B=8'd3. op_valid is high and stable for 5 cycles, drops the cycle after op_ready; active_operand returns to 0.
- Keys 1,2,7,B,A,5,B,D -> A=8'h81 (-127), B=8'hFB (-5), op_valid=1.
- Keys 1,2,8 -> '8' rejected with a one-cycle entry_err pulse, temp_value=12. Then 0,0,0,0 from empty -> fourth 0 rejected.
- key_pressed held high 10 cycles with key_value=7 -> exactly one digit accepted, temp_value=7.
- Key D in ENTER_A -> entry_err, state unchanged. Keys 4,5,C -> temp_value=0, A=0, ENTER_A. Keys pressed in HOLD -> no change, no entry_err.
- rst asserted one cycle mid-ENTER_B (A=12, temp_value=3) -> all outputs 0, ENTER_A. With KEYPAD_BACKSPACE_EN: keys 1,2,E -> temp_value=1.
